// File: rtl/button_debouncer_if.sv
// Signal bundle between the timebase/button side and the debouncer.
// The debouncer attaches through the slave modport.
interface button_debouncer_if;
  logic [31:0] counter;
  logic        btn_in;
  logic        btn_level;
  logic        btn_press;
  logic        btn_release;

  modport master (
    output counter,
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  counter,
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer sampling on rising edges of one timebase counter bit.
// Produces a debounced level plus one-cycle press/release pulses.
module button_debouncer #(
  parameter int unsigned TICK_BIT     = 16,
  parameter int unsigned STABLE_TICKS = 8
) (
  input  logic              clk,
  input  logic              reset,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  localparam logic [3:0] ACCEPT_CNT = 4'(STABLE_TICKS - 1);

  state_t     state, state_nxt;
  logic [3:0] stab_cnt, stab_cnt_nxt;
  logic       sync1, sync;
  logic       tap_d, tick;
  logic       level_r, press_r, release_r;
  logic       level_nxt, press_nxt, release_nxt;

  // Only the tap bit is consumed; the remaining counter bits are intentionally ignored.
  logic unused_counter_bits;
  assign unused_counter_bits = ^bus.counter;

  assign tick = bus.counter[TICK_BIT] & ~tap_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync      <= 1'b0;
      tap_d     <= 1'b0;
      state     <= RELEASED;
      stab_cnt  <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      sync1     <= bus.btn_in;
      sync      <= sync1;
      tap_d     <= bus.counter[TICK_BIT];
      state     <= state_nxt;
      stab_cnt  <= stab_cnt_nxt;
      level_r   <= level_nxt;
      press_r   <= press_nxt;
      release_r <= release_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    stab_cnt_nxt = stab_cnt;
    if (tick) begin
      unique case (state)
        RELEASED: begin
          if (sync) begin
            state_nxt    = PRESS_PEND;
            stab_cnt_nxt = 4'd1;
          end
        end
        PRESS_PEND: begin
          if (!sync) begin
            state_nxt    = RELEASED;
            stab_cnt_nxt = '0;
          end else if (stab_cnt == ACCEPT_CNT) begin
            state_nxt    = PRESSED;
            stab_cnt_nxt = '0;
          end else begin
            stab_cnt_nxt = stab_cnt + 4'd1;
          end
        end
        PRESSED: begin
          if (!sync) begin
            state_nxt    = RELEASE_PEND;
            stab_cnt_nxt = 4'd1;
          end
        end
        RELEASE_PEND: begin
          if (sync) begin
            state_nxt    = PRESSED;
            stab_cnt_nxt = '0;
          end else if (stab_cnt == ACCEPT_CNT) begin
            state_nxt    = RELEASED;
            stab_cnt_nxt = '0;
          end else begin
            stab_cnt_nxt = stab_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Outputs are registered so level and pulse change on the same edge as the accepting tick.
  always_comb begin
    press_nxt   = tick & (state == PRESS_PEND)   &  sync & (stab_cnt == ACCEPT_CNT);
    release_nxt = tick & (state == RELEASE_PEND) & ~sync & (stab_cnt == ACCEPT_CNT);
    level_nxt   = (level_r | press_nxt) & ~release_nxt;
  end

  assign bus.btn_level   = level_r;
  assign bus.btn_press   = press_r;
  assign bus.btn_release = release_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed plus randomized checks of button_debouncer against a sample-run reference model.
module tb_button_debouncer;
  localparam int unsigned TB_TICK_BIT = 2;
  localparam int unsigned TB_STABLE   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn;
  logic        stall;
  logic [31:0] cnt;

  button_debouncer_if bif ();
  assign bif.counter = cnt;
  assign bif.btn_in  = btn;

  button_debouncer #(.TICK_BIT(TB_TICK_BIT), .STABLE_TICKS(TB_STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: button seen two clocks late; level flips after TB_STABLE consecutive disagreeing samples.
  logic m_d1, m_d2, m_tap, m_level, exp_press, exp_rel;
  int   m_run;
  int   n_press, n_rel, seg_k, first_press;

  task automatic check(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_step();
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    if (reset) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_tap = 1'b0; m_level = 1'b0; m_run = 0;
    end else begin
      if (cnt[TB_TICK_BIT] && !m_tap) begin
        if (m_d2 != m_level) begin
          m_run++;
          if (m_run == TB_STABLE) begin
            m_level   = ~m_level;
            exp_press = m_level;
            exp_rel   = ~m_level;
            m_run     = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      m_d2  = m_d1;
      m_d1  = btn;
      m_tap = cnt[TB_TICK_BIT];
    end
  endtask

  task automatic cycle();
    logic r, s;
    r = reset;
    s = stall;
    model_step();
    @(posedge clk);
    #1;
    if (r) cnt = '0;
    else if (!s) cnt = cnt + 32'd1;
    check("level", bif.btn_level, m_level);
    check("press", bif.btn_press, exp_press);
    check("release", bif.btn_release, exp_rel);
    check("pulse_excl", bif.btn_press & bif.btn_release, 1'b0);
    seg_k++;
    if (bif.btn_press) begin
      n_press++;
      if (first_press < 0) first_press = seg_k;
    end
    if (bif.btn_release) n_rel++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic seg_start();
    n_press = 0; n_rel = 0; seg_k = 0; first_press = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, waited;
    reset = 1'b1; btn = 1'b1; stall = 1'b0; cnt = '0;
    m_d1 = 1'b0; m_d2 = 1'b0; m_tap = 1'b0; m_level = 1'b0; m_run = 0;
    exp_press = 1'b0; exp_rel = 1'b0;
    seg_start();
    #2;

    // Reset held with button pressed; press must land on the 4th tick (counter 28).
    run(5);
    check_int("rst_no_press", n_press, 0);
    reset = 1'b0;
    seg_start();
    run(40);
    check_int("t1_press_cycle", first_press, 29);
    check_int("t1_press_count", n_press, 1);

    // Release from PRESSED.
    btn = 1'b0; seg_start(); run(60);
    check_int("t5_release_count", n_rel, 1);
    check("t5_level", bif.btn_level, 1'b0);

    // Clean press.
    btn = 1'b1; seg_start(); run(60);
    check_int("t2_press_count", n_press, 1);
    check_int("t2_latency_ok", int'(first_press >= 1 && first_press <= 34), 1);
    check("t2_level", bif.btn_level, 1'b1);

    // One-cycle dropout while PRESSED changes nothing.
    btn = 1'b0; seg_start(); cycle(); btn = 1'b1; run(40);
    check_int("t5_spike_release", n_rel, 0);
    check("t5_spike_level", bif.btn_level, 1'b1);

    btn = 1'b0; seg_start(); run(60);
    check_int("t5b_release_count", n_rel, 1);

    // Bounce: toggle every 3 cycles, then hold pressed.
    seg_start();
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) btn = ~btn;
      cycle();
    end
    check_int("t3_bounce_press", n_press, 0);
    btn = 1'b1; seg_start(); run(60);
    check_int("t3_settle_press", n_press, 1);
    btn = 1'b0; run(60);

    // Short glitch (fewer than 4 ticks) is rejected.
    seg_start(); btn = 1'b1; run(20); btn = 1'b0; run(40);
    check_int("t4_glitch_press", n_press, 0);
    check("t4_level", bif.btn_level, 1'b0);

    // Reset while PRESS_PEND with two samples accepted.
    seg_start(); btn = 1'b1; waited = 0;
    while (m_run != 2 && waited < 100) begin cycle(); waited++; end
    check_int("t6_reach_pend", int'(waited < 100), 1);
    reset = 1'b1; cycle(); reset = 1'b0; btn = 1'b0;
    check("t6_rst_level", bif.btn_level, 1'b0);
    run(40);
    check_int("t6_rst_press", n_press, 0);

    // Counter wrap must not produce a tick.
    btn = 1'b1; cnt = 32'hFFFF_FFF8; seg_start(); run(40);
    check_int("t6_wrap_press_cycle", first_press, 29);
    btn = 1'b0; run(60);

    // Randomized segments with stalls, resets and near-wrap preloads.
    for (int seg = 0; seg < 80; seg++) begin
      btn   = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 7) == 0);
      len   = int'($urandom_range(1, 45));
      if ($urandom_range(0, 9) == 0) cnt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1; cycle(); reset = 1'b0;
      end
      run(len);
    end
    stall = 1'b0;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
